// File: rtl/hb_decim_mac_pkg.sv
// Shared types, default coefficient table and width helpers for the half-band decimator.
package hb_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam int DEF_SIDE_N = 7;
    localparam int DEF_CENTRE = 16384;

    // Side coefficient k (k=0 is the outermost pair); extra outer taps of a longer filter default to 0.
    function automatic int def_side(input int k, input int n_nz);
        int j;
        j = k - (n_nz - DEF_SIDE_N);
        case (j)
            0:       return 1;
            1:       return -10;
            2:       return 64;
            3:       return -275;
            4:       return 897;
            5:       return -2577;
            6:       return 10091;
            default: return 0;
        endcase
    endfunction

    function automatic int acc_width(input int data_w, input int coef_w, input int n_nz);
        return data_w + coef_w + 1 + $clog2(n_nz + 1);
    endfunction

    function automatic int addr_width(input int n_nz);
        return $clog2(n_nz + 1);
    endfunction

endpackage

// File: rtl/hb_decim_mac_mac_unit.sv
// Folded-pair multiply-accumulate: acc += (a + b) * c, with synchronous clear and enable.
module hb_mac_unit #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 36
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = DATA_W + COEF_W + 1;

    logic signed [DATA_W:0]   pair;
    logic signed [PROD_W-1:0] prod;

    assign pair = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    assign prod = pair * c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

endmodule

// File: rtl/hb_decim_mac.sv
// Half-band decimate-by-2 FIR: delay line, FSM, coefficient registers and round/saturate,
// sharing one pair-adder/multiplier across N_NZ+1 MAC cycles per output.
module hb_decim_mac
    import hb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC_W = 15,
    parameter int N_NZ   = 7
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             x_data,
    input  logic                          x_valid,
    output logic                          x_ready,
    output logic [DATA_W-1:0]             y_data,
    output logic                          y_valid,
    input  logic                          y_ready,
    input  logic                          bypass,
    input  logic                          flush,
    input  logic                          coef_we,
    input  logic [addr_width(N_NZ)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]             coef_wdata,
    output logic                          sat_flag
);

    localparam int L     = 4*N_NZ - 1;
    localparam int C     = 2*N_NZ - 1;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, N_NZ);
    localparam int AW    = addr_width(N_NZ);
    localparam int FW    = $clog2(L + 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] YMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                    state, state_nx;
    logic signed [DATA_W-1:0]  taps [L];
    logic signed [COEF_W-1:0]  coef [N_NZ+1];
    logic [FW-1:0]             fill;
    logic                      phase;
    logic [AW-1:0]             cnt;
    logic                      byp_q;
    logic                      accept, trigger, mac_en, mac_clr;
    logic signed [DATA_W-1:0]  op_a, op_b;
    logic signed [COEF_W-1:0]  op_c;
    logic signed [ACC_W-1:0]   acc, acc_sh;
    logic signed [DATA_W-1:0]  res;
    logic                      sat;

    assign accept  = x_valid && x_ready;
    assign trigger = accept && phase && (fill >= FW'(L-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    if (trigger) state_nx = bypass ? OUT : MAC;
                MAC:     if (cnt == AW'(N_NZ)) state_nx = OUT;
                OUT:     if (y_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
    end

    always_comb begin
        x_ready = (state == IDLE) && !flush;
        y_valid = (state == OUT);
        mac_en  = (state == MAC);
        mac_clr = (state == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < L; i++) taps[i] <= '0;
            fill     <= '0;
            phase    <= 1'b0;
            cnt      <= '0;
            byp_q    <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < L; i++) taps[i] <= '0;
                fill  <= '0;
                phase <= 1'b0;
            end else if (accept) begin
                taps[0] <= x_data;
                for (int i = 1; i < L; i++) taps[i] <= taps[i-1];
                phase <= ~phase;
                if (fill != FW'(L)) fill <= fill + FW'(1);
            end
            cnt <= (state == MAC && !flush) ? cnt + AW'(1) : '0;
            if (trigger) byp_q <= bypass;
            if (flush)
                sat_flag <= 1'b0;
            else if (state == OUT && !byp_q && sat)
                sat_flag <= 1'b1;
        end
    end

    // Coefficients only change while idle so a running MAC always sees one consistent set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_NZ; k++) coef[k] <= COEF_W'(def_side(k, N_NZ));
            coef[N_NZ] <= COEF_W'(DEF_CENTRE);
        end else if (state == IDLE && coef_we) begin
            for (int k = 0; k <= N_NZ; k++)
                if (coef_addr == AW'(k)) coef[k] <= coef_wdata;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        for (int k = 0; k < N_NZ; k++)
            if (cnt == AW'(k)) begin
                op_a = taps[2*k];
                op_b = taps[L-1-2*k];
            end
        if (cnt == AW'(N_NZ)) op_a = taps[C];
        for (int k = 0; k <= N_NZ; k++)
            if (cnt == AW'(k)) op_c = coef[k];
    end

    hb_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (op_a),
        .b       (op_b),
        .c       (op_c),
        .acc     (acc)
    );

    always_comb begin
        acc_sh = (acc + HALF) >>> FRAC_W;
        sat    = (acc_sh > YMAX) || (acc_sh < YMIN);
        if (acc_sh > YMAX)      res = YMAX[DATA_W-1:0];
        else if (acc_sh < YMIN) res = YMIN[DATA_W-1:0];
        else                    res = acc_sh[DATA_W-1:0];
    end

    assign y_data = (state != OUT) ? '0 : (byp_q ? taps[C] : res);

endmodule

// File: tb/tb_hb_decim_mac.sv
// Bench for hb_decim_mac: hand vectors for rounding/saturation plus randomized traffic
// checked against a direct-convolution reference model.
module tb_hb_decim_mac;

    localparam int NNZ = 7;
    localparam int L   = 27;
    localparam int C   = 13;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [15:0] x_data = '0;
    logic        x_valid = 1'b0, x_ready;
    logic [15:0] y_data;
    logic        y_valid, y_ready = 1'b0;
    logic        bypass = 1'b0, flush = 1'b0, coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        sat_flag;

    hb_decim_mac #(.DATA_W(16), .COEF_W(16), .FRAC_W(15), .N_NZ(NNZ)) dut (
        .clk(clk), .reset_n(reset_n), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .bypass(bypass), .flush(flush),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int trig; int lat; } exp_t;
    typedef struct { int centre; int x; int exp_y; bit exp_sat; } vec_t;

    int   vecs = 0, errs = 0, cyc = 0, n_out = 0, last_y = 0;
    int   hist[$];
    exp_t expq[$];
    bit   seen = 0, last_acc = 0, obs_yv = 0, obs_xr = 0;
    int   coef_m[8];

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic load_def_model();
        coef_m = '{1, -10, 64, -275, 897, -2577, 10091, 16384};
    endtask

    // Reference: plain 27-tap convolution over the samples seen since the last flush.
    function automatic int model_out(input bit byp);
        int n, h;
        longint acc, r;
        n = hist.size() - 1;
        if (byp) return hist[n-C];
        acc = 0;
        for (int j = 0; j < L; j++) begin
            if (j == C)          h = coef_m[NNZ];
            else if (j % 2 == 1) h = 0;
            else if (j < C)      h = coef_m[j/2];
            else                 h = coef_m[(L-1-j)/2];
            acc += longint'(h) * longint'(hist[n-j]);
        end
        r = (acc + 16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic int rnd16();
        logic [15:0] v;
        v = 16'($urandom);
        return int'($signed(v));
    endfunction

    task automatic step(input bit xv, input int xd, input bit yr, input bit fl, input bit byp,
                        input bit we, input int wa, input int wd);
        int n;
        @(negedge clk);
        x_valid = xv; x_data = 16'(xd); y_ready = yr; flush = fl; bypass = byp;
        coef_we = we; coef_addr = 3'(wa); coef_wdata = 16'(wd);
        #1;
        obs_yv = y_valid; obs_xr = x_ready; last_acc = 0;
        if (y_valid) begin
            if (expq.size() == 0) begin
                vecs++; errs++;
                $display("FAIL spurious_y_valid: got y_valid=1 y_data=%0d, expected no output (cycle %0d)",
                         $signed(y_data), cyc);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - expq[0].trig, expq[0].lat);
                    seen = 1;
                end
                chk("y_data", int'($signed(y_data)), expq[0].val);
                if (!yr) chk("x_ready_while_out", int'(x_ready), 0);
                if (yr) begin
                    last_y = int'($signed(y_data));
                    n_out++;
                    void'(expq.pop_front());
                    seen = 0;
                end
            end
        end
        if (we) coef_m[wa] = wd;
        if (fl) begin
            hist.delete(); expq.delete(); seen = 0;
        end else if (xv && x_ready) begin
            last_acc = 1;
            hist.push_back(xd);
            n = hist.size() - 1;
            if (n >= L && n % 2 == 1) expq.push_back('{model_out(byp), cyc, byp ? 1 : NNZ + 2});
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_flush();
        step(0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic wr_coef(input int a, input int v);
        step(0, 0, 1, 0, 0, 1, a, v);
    endtask

    task automatic send(input int xd, input bit byp, input int bp);
        last_acc = 0;
        for (int i = 0; i < 100 && !last_acc; i++)
            step(1, xd, ($urandom_range(99) >= bp), 0, byp, 0, 0, 0);
        if (!last_acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && expq.size() > 0; i++) idle(1);
        if (expq.size() > 0) begin
            chk("drain_timeout", expq.size(), 0);
            expq.delete(); seen = 0;
        end
    endtask

    task automatic restore_defaults();
        int d[8];
        d = '{1, -10, 64, -275, 897, -2577, 10091, 16384};
        for (int k = 0; k < 8; k++) wr_coef(k, d[k]);
    endtask

    vec_t tbl[7];
    int   n0, held, xd;

    initial begin
        // Centre-only filter: y = round(x*centre/2^15), saturated.
        tbl[0] = '{16384,   1000,   500, 1'b0};
        tbl[1] = '{16384,      1,     1, 1'b0};
        tbl[2] = '{16384,     -1,     0, 1'b0};
        tbl[3] = '{16384,     -3,    -1, 1'b0};
        tbl[4] = '{32767,  32767, 32766, 1'b0};
        tbl[5] = '{-32768, -32768, 32767, 1'b1};
        tbl[6] = '{-32768, 32767, -32767, 1'b0};
        load_def_model();

        repeat (3) @(negedge clk);
        #1;
        chk("reset_y_valid", int'(y_valid), 0);
        chk("reset_y_data", int'(y_data), 0);
        chk("reset_x_ready", int'(x_ready), 1);
        chk("reset_sat_flag", int'(sat_flag), 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drain();
            do_flush();
            for (int k = 0; k < NNZ; k++) wr_coef(k, 0);
            wr_coef(NNZ, tbl[i].centre);
            for (int s = 0; s < 28; s++) send(tbl[i].x, 0, 0);
            drain();
            idle(1);
            chk("tbl_y", last_y, tbl[i].exp_y);
            chk("tbl_sat", int'(sat_flag), int'(tbl[i].exp_sat));
        end
        restore_defaults();

        // DC gain of the default set is 32766/32768.
        do_flush();
        for (int s = 0; s < 100; s++) send(1000, 0, 0);
        drain();
        idle(1);
        chk("dc_y", last_y, 1000);
        chk("dc_sat", int'(sat_flag), 0);

        do_flush();
        n0 = n_out;
        send(32767, 0, 0);
        for (int s = 0; s < 59; s++) send(0, 0, 0);
        drain();
        chk("impulse_outputs", n_out - n0, 17);

        // Backpressure: hold OUT for 10 cycles while a sample is offered.
        do_flush();
        n0 = n_out;
        for (int s = 0; s < 28; s++) send(rnd16(), 0, 0);
        xd = rnd16();
        held = 0;
        for (int i = 0; i < 18; i++) begin
            step(1, xd, 0, 0, 0, 0, 0, 0);
            if (obs_yv) held++;
        end
        chk("bp_hold_cycles", held, 10);
        send(xd, 0, 0);
        for (int s = 0; s < 100; s++) send(rnd16(), 0, 30);
        drain();
        chk("bp_outputs", n_out - n0, 51);

        // Random coefficients, gaps, backpressure and bypass.
        for (int k = 0; k < NNZ; k++) wr_coef(k, $urandom_range(12000) - 6000);
        wr_coef(NNZ, rnd16());
        do_flush();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0) step(0, 0, $urandom_range(1), 0, 0, 0, 0, 0);
            else                        send(rnd16(), $urandom_range(5) == 0, 30);
        end
        drain();
        restore_defaults();

        for (int k = 0; k < NNZ; k++) wr_coef(k, 16000);
        wr_coef(NNZ, 32767);
        do_flush();
        for (int s = 0; s < 40; s++) send(32767, 0, 0);
        drain();
        chk("sat_pos_y", last_y, 32767);
        for (int s = 0; s < 40; s++) send(-32768, 0, 0);
        drain();
        chk("sat_neg_y", last_y, -32768);
        idle(1);
        chk("sat_flag_set", int'(sat_flag), 1);
        do_flush();
        idle(1);
        chk("sat_flag_flushed", int'(sat_flag), 0);
        restore_defaults();

        do_flush();
        for (int s = 0; s < 60; s++) send(s, 1, 0);
        drain();
        chk("bypass_y", last_y, 46);

        // Abort: flush in the 3rd MAC cycle.
        do_flush();
        for (int s = 0; s < 28; s++) send(rnd16(), 0, 0);
        idle(2);
        do_flush();
        idle(1);
        chk("abort_y_valid", int'(obs_yv), 0);
        chk("abort_x_ready", int'(obs_xr), 1);
        n0 = n_out;
        for (int s = 0; s < 27; s++) send(rnd16(), 0, 0);
        idle(20);
        chk("abort_no_out", n_out - n0, 0);
        send(rnd16(), 0, 0);
        drain();
        chk("abort_one_out", n_out - n0, 1);

        // Reset mid-MAC, also reloading default coefficients.
        for (int k = 0; k < NNZ; k++) wr_coef(k, 500);
        do_flush();
        for (int s = 0; s < 28; s++) send(rnd16(), 0, 0);
        idle(3);
        @(negedge clk);
        reset_n = 1'b0;
        x_valid = 1'b0; flush = 1'b0; coef_we = 1'b0;
        #1;
        chk("rst_abort_y_valid", int'(y_valid), 0);
        chk("rst_abort_x_ready", int'(x_ready), 1);
        hist.delete(); expq.delete(); seen = 0;
        load_def_model();
        @(negedge clk);
        reset_n = 1'b1;
        n0 = n_out;
        idle(20);
        chk("rst_no_out", n_out - n0, 0);
        for (int s = 0; s < 30; s++) send(1000, 0, 0);
        drain();
        chk("rst_dc_y", last_y, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
